// File: rtl/dmem_resp_ctrl.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY-cycle access, valid/ready
// response. Optional per-byte store strobes are enabled by the DMEM_WSTRB_EN macro.
module dmem_resp_ctrl #(
   parameter int DMEM_DEPTH      = 1024,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int LATENCY         = 2
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // the sender holds valid and its payload stable until that edge.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t                       state_q, state_d;
   logic [3:0]                   cnt_q, cnt_d;
   logic [DMEM_ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic                         write_q, write_d;
   logic [31:0]                  wdata_q, wdata_d;
   logic                         err_q, err_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic                         rsp_err_q, rsp_err_d;

   logic [31:0]                  mem [DMEM_DEPTH];

   logic                         in_idle;
   logic                         req_err;
   logic [DMEM_ADDR_WIDTH-1:0]   req_idx;
   logic                         commit;
   logic                         mem_we;
   logic [DMEM_ADDR_WIDTH-1:0]   cm_idx;
   logic                         cm_write;
   logic [31:0]                  cm_wdata;
   logic                         cm_err;
   logic [3:0]                   cm_be;

   assign in_idle = (state_q == ST_IDLE);
   assign req_idx = req_addr[DMEM_ADDR_WIDTH+1:2];
   assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:DMEM_ADDR_WIDTH+2]);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_d = LAT_M1;
               if (LATENCY == 1) state_d = ST_RESP;
               else              state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // With LATENCY==1 the commit edge is the accept edge, so the access uses the live request.
   always_comb begin
      cm_idx   = in_idle ? req_idx   : idx_q;
      cm_write = in_idle ? req_write : write_q;
      cm_wdata = in_idle ? req_wdata : wdata_q;
      cm_err   = in_idle ? req_err   : err_q;
   end

`ifdef DMEM_WSTRB_EN
   logic [3:0] wstrb_q, wstrb_d;

   always_comb begin
      wstrb_d = wstrb_q;
      if (in_idle && req_valid) wstrb_d = req_wstrb;
      cm_be = in_idle ? req_wstrb : wstrb_q;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) wstrb_q <= 4'b0000;
      else          wstrb_q <= wstrb_d;
   end
`else
   logic unused_wstrb;
   assign unused_wstrb = ^req_wstrb;
   assign cm_be        = 4'b1111;
`endif

   always_comb begin
      idx_d     = idx_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      rsp_err_d = rsp_err_q;
      if (in_idle && req_valid) begin
         idx_d   = req_idx;
         write_d = req_write;
         wdata_d = req_wdata;
         err_d   = req_err;
      end
      if (commit) begin
         rsp_err_d = cm_err;
         rdata_d   = (cm_write || cm_err) ? 32'h0 : mem[cm_idx];
      end
   end

   assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);
   assign mem_we = commit && cm_write && !cm_err;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         wdata_q   <= 32'h0;
         err_q     <= 1'b0;
         rdata_q   <= 32'h0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Array contents survive reset; only the control path is cleared.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cm_be[i]) mem[cm_idx][8*i +: 8] <= cm_wdata[8*i +: 8];
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Directed bench for dmem_resp_ctrl: three instances with LATENCY 2, 3 and 1 sharing one clock.
module tb_dmem_resp_ctrl;

   logic        clk;
   logic [2:0]  reset_b;
   logic [2:0]  req_valid;
   logic [2:0]  req_write;
   logic [2:0]  rsp_ready;
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wstrb [3];
   wire  [2:0]  req_ready;
   wire  [2:0]  rsp_valid;
   wire  [2:0]  rsp_err;
   wire  [31:0] rsp_rdata [3];
   wire  [1:0]  dbg_state [3];

   int checks;
   int errors;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_resp_ctrl #(
         .DMEM_DEPTH      (1024),
         .DMEM_ADDR_WIDTH (10),
         .LATENCY         ((g == 0) ? 2 : ((g == 1) ? 3 : 1))
      ) u_dut (
         .clk       (clk),
         .reset_b   (reset_b[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_wstrb (req_wstrb[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .dbg_state (dbg_state[g])
      );
   end

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Driver tasks: entered and left at posedge+1.
   task automatic send_req(input int u, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, output int wait_cyc);
      req_write[u] = wr;
      req_addr[u]  = addr;
      req_wdata[u] = wdata;
      req_wstrb[u] = strb;
      req_valid[u] = 1'b1;
      wait_cyc = 0;
      @(negedge clk);
      while (!req_ready[u] && wait_cyc < 50) begin
         wait_cyc++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
   endtask

   task automatic wait_rsp(input int u, output int lat, output logic [31:0] rdata, output logic err);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid[u] && lat < 50);
      rdata = rsp_rdata[u];
      err   = rsp_err[u];
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (req_ready[u] !== 1'b1) begin errors++; $display("FAIL rst_req_ready[%0d]: got %b want 1", u, req_ready[u]); end
         checks++;
         if (rsp_valid[u] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid[%0d]: got %b want 0", u, rsp_valid[u]); end
         checks++;
         if (rsp_rdata[u] !== 32'h0) begin errors++; $display("FAIL rst_rdata[%0d]: got %h want 0", u, rsp_rdata[u]); end
         checks++;
         if (rsp_err[u] !== 1'b0) begin errors++; $display("FAIL rst_err[%0d]: got %b want 0", u, rsp_err[u]); end
         checks++;
         if (dbg_state[u] !== 2'd0) begin errors++; $display("FAIL rst_state[%0d]: got %0d want 0", u, dbg_state[u]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_load;
      int wc, lat;
      logic [31:0] rd;
      logic er;
      send_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (wc !== 0) begin errors++; $display("FAIL st_accept_wait: got %0d want 0", wc); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL st_latency: got %0d want 2", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h want 00000000", rd); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL st_err: got %b want 0", er); end
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL post_hs_valid: got %b want 0", rsp_valid[0]); end
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL post_hs_ready: got %b want 1", req_ready[0]); end
      @(posedge clk); #1;
      send_req(0, 1'b0, 32'h10, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL ld_latency: got %0d want 2", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL ld_err: got %b want 0", er); end
   endtask

   task automatic test_errors;
      int wc, lat;
      logic [31:0] rd;
      logic er;
      send_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      send_req(0, 1'b0, 32'h13, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL misal_latency: got %0d want 2", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL misal_rdata: got %h want 00000000", rd); end
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL misal_err: got %b want 1", er); end
      // 0x1000 aliases word 0 if the range check were missing.
      send_req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL oor_latency: got %0d want 2", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 00000000", rd); end
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", er); end
      send_req(0, 1'b0, 32'h0, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_unchanged: got %h want cafef00d", rd); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL oor_reload_err: got %b want 0", er); end
   endtask

   task automatic test_backpressure;
      int wc, lat;
      logic [31:0] rd;
      logic er;
      send_req(0, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      rsp_ready[0] = 1'b0;
      send_req(0, 1'b0, 32'h30, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", lat); end
      checks++;
      if (rd !== 32'h5A5A1234) begin errors++; $display("FAIL bp_rdata: got %h want 5a5a1234", rd); end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            req_write[0] = 1'b1;
            req_addr[0]  = 32'h30;
            req_wdata[0] = 32'h0;
            req_wstrb[0] = 4'hF;
            req_valid[0] = 1'b1;
         end
         @(negedge clk);
         checks++;
         if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid[0]); end
         checks++;
         if (rsp_rdata[0] !== 32'h5A5A1234) begin errors++; $display("FAIL bp_hold_rdata[%0d]: got %h want 5a5a1234", i, rsp_rdata[0]); end
         checks++;
         if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL bp_hold_err[%0d]: got %b want 0", i, rsp_err[0]); end
         checks++;
         if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready[0]); end
         @(posedge clk); #1;
         req_valid[0] = 1'b0;
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid[0]); end
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready[0]); end
      @(posedge clk); #1;
      send_req(0, 1'b0, 32'h30, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (rd !== 32'h5A5A1234) begin errors++; $display("FAIL bp_pulse_ignored: got %h want 5a5a1234", rd); end
   endtask

   task automatic test_reset_midop;
      int wc, lat;
      logic [31:0] rd;
      logic er;
      send_req(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, wc);
      wait_rsp(1, lat, rd, er);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL l3_latency: got %0d want 3", lat); end
      send_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF, wc);
      reset_b[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_b[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d]: got %b want 0", i, rsp_valid[1]); end
         checks++;
         if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL midrst_ready[%0d]: got %b want 1", i, req_ready[1]); end
      end
      @(posedge clk); #1;
      send_req(1, 1'b0, 32'h20, 32'h0, 4'hF, wc);
      wait_rsp(1, lat, rd, er);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL midrst_ld_latency: got %0d want 3", lat); end
      checks++;
      if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_dropped_store: got %h want 0badf00d", rd); end
   endtask

   task automatic test_back_to_back;
      int wc, lat, acc;
      logic [31:0] rd;
      logic er;
      acc = 0;
      req_write[2] = 1'b1;
      req_addr[2]  = 32'h50;
      req_wdata[2] = 32'h600DCAFE;
      req_wstrb[2] = 4'hF;
      req_valid[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (req_ready[2]) acc++;
         checks++;
         if (req_ready[2] !== (i % 2 == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready[2], (i % 2 == 0)); end
         checks++;
         if (rsp_valid[2] !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, rsp_valid[2], (i % 2 == 1)); end
         if (rsp_valid[2]) begin
            checks++;
            if (rsp_rdata[2] !== 32'h0 || rsp_err[2] !== 1'b0) begin
               errors++; $display("FAIL b2b_rsp[%0d]: got %h/%b want 00000000/0", i, rsp_rdata[2], rsp_err[2]);
            end
         end
         @(posedge clk); #1;
      end
      req_valid[2] = 1'b0;
      checks++;
      if (acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", acc); end
      @(posedge clk); #1;
      send_req(2, 1'b0, 32'h50, 32'h0, 4'hF, wc);
      wait_rsp(2, lat, rd, er);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL l1_latency: got %0d want 1", lat); end
      checks++;
      if (rd !== 32'h600DCAFE) begin errors++; $display("FAIL l1_rdata: got %h want 600dcafe", rd); end
   endtask

   task automatic test_wstrb;
      int wc, lat;
      logic [31:0] rd, exp_mix, exp_zero;
      logic er;
`ifdef DMEM_WSTRB_EN
      exp_mix  = 32'hAA22CC44;
      exp_zero = 32'hAA22CC44;
`else
      exp_mix  = 32'h11223344;
      exp_zero = 32'hFFFFFFFF;
`endif
      send_req(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      send_req(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, wc);
      wait_rsp(0, lat, rd, er);
      send_req(0, 1'b0, 32'h40, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (rd !== exp_mix) begin errors++; $display("FAIL wstrb_0101: got %h want %h", rd, exp_mix); end
      send_req(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL wstrb_0000_rsp: got lat %0d err %b want lat 2 err 0", lat, er); end
      send_req(0, 1'b0, 32'h40, 32'h0, 4'hF, wc);
      wait_rsp(0, lat, rd, er);
      checks++;
      if (rd !== exp_zero) begin errors++; $display("FAIL wstrb_0000: got %h want %h", rd, exp_zero); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_b   = 3'b000;
      req_valid = 3'b000;
      req_write = 3'b000;
      rsp_ready = 3'b111;
      for (int u = 0; u < 3; u++) begin
         req_addr[u]  = 32'h0;
         req_wdata[u] = 32'h0;
         req_wstrb[u] = 4'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset_b = 3'b111;
      test_reset();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_wstrb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
